// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 5..DBIT data bits LSB first, optional parity, 1/2 stops.
// Parity support is compiled in only when UART_TX_CFG_PARITY_EN is defined.
module uart_tx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_tick,
    input  logic                       tx_start,
    input  logic [DBIT-1:0]            tx_din,
    input  logic [$clog2(DBIT+1)-1:0]  cfg_dbits,
    input  logic [1:0]                 cfg_parity,
    input  logic                       cfg_stop2,
    output logic                       tx_ready,
    output logic                       tx_done_tick,
    output logic                       tx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int DW = $clog2(DBIT+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_CFG_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [DW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   dbits_q, dbits_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            stop2_q, stop2_d;
    logic            tx_q, tx_d;
    logic            last_tick;
    logic [DW-1:0]   dbits_eff;
`ifdef UART_TX_CFG_PARITY_EN
    logic [1:0]      pmode_q, pmode_d;
    logic            par_q, par_d;
    logic            par_en;
    assign par_en = pmode_q[0] ^ pmode_q[1];
`else
    logic            unused_parity;
    assign unused_parity = ^cfg_parity;
`endif

    assign last_tick = s_tick && (tick_q == TW'(OVERSAMPLE-1));
    // Out-of-range widths fall back to the full word
    assign dbits_eff = (cfg_dbits < DW'(5) || cfg_dbits > DW'(DBIT)) ? DW'(DBIT) : cfg_dbits;

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        dbits_d      = dbits_q;
        data_d       = data_q;
        stop2_d      = stop2_q;
        tx_d         = tx_q;
        tx_done_tick = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
        pmode_d      = pmode_q;
        par_d        = par_q;
`endif
        if (state_q != S_IDLE && s_tick)
            tick_d = last_tick ? '0 : tick_q + TW'(1);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    data_d  = tx_din;
                    dbits_d = dbits_eff;
                    stop2_d = cfg_stop2;
                    tick_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
`ifdef UART_TX_CFG_PARITY_EN
                    pmode_d = cfg_parity;
                    par_d   = 1'b0;
`endif
                end
            end
            S_START: begin
                if (last_tick) begin
                    tx_d    = data_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_tick) begin
`ifdef UART_TX_CFG_PARITY_EN
                    par_d = par_q ^ data_q[0];
`endif
                    if (bit_q == dbits_q - DW'(1)) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`ifdef UART_TX_CFG_PARITY_EN
                        if (par_en) begin
                            // odd mode (2'b10) inverts the running XOR
                            tx_d    = par_q ^ data_q[0] ^ pmode_q[1];
                            state_d = S_PARITY;
                        end
`endif
                    end else begin
                        bit_d  = bit_q + DW'(1);
                        data_d = data_q >> 1;
                        tx_d   = data_q[1];
                    end
                end
            end
`ifdef UART_TX_CFG_PARITY_EN
            S_PARITY: begin
                if (last_tick) begin
                    bit_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (last_tick) begin
                    if (stop2_q && bit_q == '0) begin
                        bit_d = DW'(1);
                    end else begin
                        tx_done_tick = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            dbits_q <= DW'(DBIT);
            data_q  <= '0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
`ifdef UART_TX_CFG_PARITY_EN
            pmode_q <= 2'b00;
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            dbits_q <= dbits_d;
            data_q  <= data_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
`ifdef UART_TX_CFG_PARITY_EN
            pmode_q <= pmode_d;
            par_q   <= par_d;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (DBIT=8, OVERSAMPLE=16, s_tick every 4 clocks).
module tb_uart_tx_cfg;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_din = 8'h00;
    logic [3:0] cfg_dbits = 4'd8;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       tx_ready, tx_done_tick, tx;

    int n_chk = 0;
    int n_pass = 0;
    int tdiv = 0;

`ifdef UART_TX_CFG_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    uart_tx_cfg #(.DBIT(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
        .tx_din(tx_din), .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx(tx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv   = (tdiv == 3) ? 0 : tdiv + 1;
        s_tick = (tdiv == 3);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Sends one frame and samples the line mid-bit; bits[i] is the i-th bit time (0 = start).
    task automatic run_frame(input string nm, input logic [7:0] din, input logic [3:0] db,
                             input logic [1:0] par, input logic st2, input int inj_tick,
                             input int rst_tick, output logic [31:0] bits, output int ticks,
                             output int dones);
        int k;
        @(negedge clk); #2;
        tx_din = din; cfg_dbits = db; cfg_parity = par; cfg_stop2 = st2; tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        tx_din = ~din; cfg_dbits = 4'd5; cfg_parity = ~par; cfg_stop2 = ~st2;
        chk({nm, "_start_low"}, {31'd0, tx}, 32'd0);
        chk({nm, "_busy"}, {31'd0, tx_ready}, 32'd0);
        bits = '0; ticks = 0; dones = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #2;
            tx_start = 1'b0;
            if (tx_done_tick) dones++;
            if (s_tick) begin
                ticks++;
                k = ticks - 1;
                if (k % 16 == 8 && k / 16 < 32) bits[k / 16] = tx;
                if (ticks == inj_tick) begin
                    tx_din = 8'hFF;
                    tx_start = 1'b1;
                end
                if (ticks == rst_tick) begin
                    reset = 1'b1;
                    break;
                end
            end
            if (tx_done_tick) break;
        end
    endtask

    task automatic frame_check(input string nm, input logic [7:0] din, input logic [3:0] db,
                               input logic [1:0] par, input logic st2, input int inj,
                               input logic [31:0] exp_bits, input int exp_ticks);
        logic [31:0] bits;
        int ticks, dones;
        run_frame(nm, din, db, par, st2, inj, -1, bits, ticks, dones);
        chk({nm, "_bits"}, bits, exp_bits);
        chk({nm, "_ticks"}, ticks, exp_ticks);
        chk({nm, "_dones"}, dones, 1);
        @(posedge clk); #1;
        chk({nm, "_ready_after"}, {31'd0, tx_ready}, 32'd1);
        chk({nm, "_idle_tx"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        logic [31:0] bits;
        int ticks, dones;

        // reset held with a start request pending
        reset = 1'b1; tx_start = 1'b1; tx_din = 8'h55;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_done", {31'd0, tx_done_tick}, 32'd0);
        @(negedge clk); #2;
        reset = 1'b0; tx_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_tx", {31'd0, tx}, 32'd1);

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        frame_check("8n1_55", 8'h55, 4'd8, 2'b00, 1'b0, -1, 32'h2AA, 160);

        // 7E2 0x83: data 1,1,0,0,0,0,0 -> XOR 0, even parity bit 0
        frame_check("7e2_83", 8'h83, 4'd7, 2'b01, 1'b1, -1,
                    PAR_EN ? 32'h606 : 32'h306, PAR_EN ? 176 : 160);

        // 8O1 0x00: odd parity bit 1
        frame_check("8o1_00", 8'h00, 4'd8, 2'b10, 1'b0, -1,
                    PAR_EN ? 32'h600 : 32'h200, PAR_EN ? 176 : 160);

        // reserved parity mode behaves as none
        frame_check("8r1_00", 8'h00, 4'd8, 2'b11, 1'b0, -1, 32'h200, 160);

        // cfg_dbits=3 clamps to 8: 1,0,1,0,0,1,0,1
        frame_check("clamp_a5", 8'hA5, 4'd3, 2'b00, 1'b0, -1, 32'h34A, 160);

        // request with 0xFF during DATA is ignored
        frame_check("busy_inj", 8'h55, 4'd8, 2'b00, 1'b0, 50, 32'h2AA, 160);

        // reset during DATA aborts the frame with no done pulse
        run_frame("abort", 8'h55, 4'd8, 2'b00, 1'b0, -1, 60, bits, ticks, dones);
        chk("abort_reached", ticks, 60);
        @(posedge clk); #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_ready", {31'd0, tx_ready}, 32'd1);
        chk("abort_done", {31'd0, tx_done_tick}, 32'd0);
        @(negedge clk); #2;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #2;
            if (tx_done_tick) dones++;
        end
        chk("abort_no_done", dones + dones_before(dones), 0);
        chk("abort_idle_tx", {31'd0, tx}, 32'd1);

        // back to normal after abort
        frame_check("after_abort", 8'h0F, 4'd8, 2'b00, 1'b0, -1, 32'h21E, 160);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    function automatic int dones_before(input int d);
        return 0 * d;
    endfunction
endmodule
